// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, default
// geometry and frame constants used by the loader and the processor top level.
package inst_loader_pkg;

    localparam int ADDR_W_DEF    = 6;
    localparam int MAX_WORDS_DEF = 64;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHECK = 3'd5,
        ST_RUN   = 3'd6,
        ST_ERROR = 3'd7
    } load_state_e;

    // Running frame checksum: plain XOR of every word byte.
    function automatic logic [BYTE_W-1:0] chk_fold(input logic [BYTE_W-1:0] chk,
                                                   input logic [BYTE_W-1:0] b);
        return chk ^ b;
    endfunction

    function automatic logic is_busy_state(input load_state_e s);
        logic r;
        case (s)
            ST_COUNT, ST_HI, ST_LO, ST_WRITE, ST_CHECK: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_rx_state(input load_state_e s);
        logic r;
        case (s)
            ST_COUNT, ST_HI, ST_LO, ST_CHECK: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_loader.sv
// Byte-stream program loader: receives count, words (high byte first) and an
// XOR checksum, writes instruction memory and hands control to the processor.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              controller_enable,
    output logic              restart,
    output logic              busy,
    output logic              load_error
);

    load_state_e       state_r;
    load_state_e       next_s;
    logic              accept_s;
    logic              last_word_s;
    logic              n_bad_s;
    logic [BYTE_W-1:0] n_r;
    logic [BYTE_W-1:0] chk_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] wdata_r;
    logic              byte_ready_r;
    logic              imem_we_r;
    logic              enable_r;
    logic              restart_r;
    logic              busy_r;
    logic              error_r;

    // Next-state decode; start overrides every state and aborts any frame.
    always_comb begin
        next_s      = state_r;
        accept_s    = byte_valid & byte_ready_r;
        last_word_s = ((BYTE_W'(addr_r) + 8'd1) == n_r);
        n_bad_s     = (byte_data == 8'd0) || (byte_data > BYTE_W'(MAX_WORDS));
        if (start) begin
            next_s = ST_COUNT;
        end else begin
            case (state_r)
                ST_IDLE:  next_s = ST_IDLE;
                ST_COUNT: begin
                    if (accept_s) begin
                        next_s = n_bad_s ? ST_ERROR : ST_HI;
                    end else begin
                        next_s = ST_COUNT;
                    end
                end
                ST_HI:    next_s = accept_s ? ST_LO : ST_HI;
                ST_LO:    next_s = accept_s ? ST_WRITE : ST_LO;
                ST_WRITE: next_s = last_word_s ? ST_CHECK : ST_HI;
                ST_CHECK: begin
                    if (accept_s) begin
                        next_s = (byte_data == chk_r) ? ST_RUN : ST_ERROR;
                    end else begin
                        next_s = ST_CHECK;
                    end
                end
                ST_RUN:   next_s = ST_RUN;
                ST_ERROR: next_s = ST_ERROR;
                default:  next_s = ST_IDLE;
            endcase
        end
    end

    // State and control outputs, all registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            byte_ready_r <= 1'b0;
            imem_we_r    <= 1'b0;
            enable_r     <= 1'b0;
            restart_r    <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= next_s;
            byte_ready_r <= is_rx_state(next_s);
            imem_we_r    <= (next_s == ST_WRITE);
            enable_r     <= (next_s == ST_RUN);
            restart_r    <= (next_s == ST_RUN) && (state_r != ST_RUN);
            busy_r       <= is_busy_state(next_s);
            error_r      <= (next_s == ST_ERROR);
        end
    end

    // Byte datapath; the address holds at N-1 after the last word so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_r     <= 8'd0;
            chk_r   <= 8'd0;
            addr_r  <= '0;
            wdata_r <= 16'd0;
        end else if (start) begin
            chk_r  <= 8'd0;
            addr_r <= '0;
        end else begin
            case (state_r)
                ST_COUNT: begin
                    if (accept_s && !n_bad_s) begin
                        n_r <= byte_data;
                    end
                end
                ST_HI: begin
                    if (accept_s) begin
                        wdata_r[15:8] <= byte_data;
                        chk_r         <= chk_fold(chk_r, byte_data);
                    end
                end
                ST_LO: begin
                    if (accept_s) begin
                        wdata_r[7:0] <= byte_data;
                        chk_r        <= chk_fold(chk_r, byte_data);
                    end
                end
                ST_WRITE: begin
                    if (!last_word_s) begin
                        addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_ready        = byte_ready_r;
    assign imem_we           = imem_we_r;
    assign imem_addr         = addr_r;
    assign imem_wdata        = wdata_r;
    assign controller_enable = enable_r;
    assign restart           = restart_r;
    assign busy              = busy_r;
    assign load_error        = error_r;

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_W, default 6, instruction-memory address width (64 words, matching the 6-bit PC).
REQ-002 Parameter MAX_WORDS, default 64, largest legal program length in words.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a new program load.
REQ-006 byte_valid  input  1  upstream byte stream holds a valid byte.
REQ-007 byte_data  input  8  upstream byte payload.
REQ-008 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction-memory write address.
REQ-011 imem_wdata  output  16  instruction word to write.
REQ-012 controller_enable  output  1  level that gates the processor clock controller.
REQ-013 restart  output  1  one-cycle pulse to the controller restart input.
REQ-014 busy  output  1  high while a load is in progress (COUNT, HI, LO, WRITE, CHECK).
REQ-015 load_error  output  1  sticky error flag, cleared only by start or reset.

Function
REQ-016 A byte SHALL be consumed only on a rising edge where byte_valid and byte_ready are both 1; byte_ready SHALL not depend combinationally on byte_valid.
REQ-017 The load frame SHALL be: count byte N, then N words sent high byte first, then one checksum byte equal to the XOR of all 2N word bytes.
REQ-018 States SHALL be IDLE, COUNT, HI, LO, WRITE, CHECK, RUN, ERROR.
REQ-019 IDLE/RUN/ERROR + start -> COUNT; the same edge SHALL drop controller_enable, clear load_error, clear the checksum and set the write address to 0.
REQ-020 COUNT: byte_ready=1; an accepted N of 0 or N>MAX_WORDS -> ERROR, otherwise latch N and go to HI.
REQ-021 HI: byte_ready=1; an accepted byte goes to imem_wdata[15:8] and is XORed into the checksum, then -> LO.
REQ-022 LO: byte_ready=1; an accepted byte goes to imem_wdata[7:0] and is XORed into the checksum, then -> WRITE.
REQ-023 WRITE: byte_ready=0, imem_we=1 for exactly one cycle at the current imem_addr; the address then increments; -> CHECK if this was word N, else -> HI.
REQ-024 CHECK: byte_ready=1; an accepted byte equal to the running checksum -> RUN, otherwise -> ERROR.
REQ-025 On entry to RUN, restart SHALL pulse for exactly one cycle and controller_enable SHALL rise on the same edge and stay high until the next start or reset.
REQ-026 ERROR: load_error=1, controller_enable=0, byte_ready=0; bytes offered are ignored.
REQ-027 start received in COUNT/HI/LO/WRITE/CHECK SHALL abort the frame and restart at COUNT with address 0; no imem_we is issued on that edge.
REQ-028 imem_addr SHALL never exceed N-1 during a load; address arithmetic is ADDR_W bits with no wrap inside a legal frame.
REQ-029 Latency: the WRITE strobe occurs on the cycle after the low byte is accepted; RUN is entered on the edge that accepts a correct checksum.

Reset
REQ-030 While rst=0 the state SHALL be IDLE and every output SHALL be 0 (imem_addr=0, imem_wdata=0, controller_enable=0, restart=0, busy=0, load_error=0, byte_ready=0).
REQ-031 Reset asserted mid-load SHALL abandon the frame immediately with no further imem_we; memory contents already written are left unchanged.

Structure
REQ-032 The state encoding, the ADDR_W/MAX_WORDS defaults and the frame constants SHALL live in a shared package used by the processor top level.
REQ-033 The block SHALL be a single module with no sub-modules; the byte/checksum datapath is inline.

Verification
REQ-034 Reset, start, frame N=2, words 0x1234 and 0xABCD, checksum 0x12^0x34^0xAB^0xCD=0x40 -> writes at addr 0 and 1, restart pulses once, controller_enable=1.
REQ-035 Same frame with checksum 0x41 -> state ERROR, load_error=1, controller_enable=0, no restart pulse.
REQ-036 N=0, and separately N=65 -> ERROR on the next edge, no imem_we.
REQ-037 N=64 load with byte_valid toggled randomly -> exactly 64 writes at addresses 0..63, one per WRITE cycle, bytes never dropped or duplicated.
REQ-038 start pulsed after the first word's high byte, then a full N=1 frame 0x00FF with checksum 0xFF -> a single write of 0x00FF to addr 0, followed by RUN.
REQ-039 rst driven low in LO state -> all outputs 0 asynchronously; after rst is released the state is IDLE and byte_ready=0.
